// File: rtl/instr_mem_pkg.sv
// Shared constants and FSM state type for the instruction memory.
package instr_mem_pkg;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/instr_mem_array.sv
// imem_array: DEPTH-word storage, one synchronous write port, one asynchronous read port.
// Contents are never reset; the owner fills them with a sweep.
module imem_array
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int              LP_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_in_range;
  logic              w_rd_in_range;

  assign w_wr_in_range = ({1'b0, i_wr_addr} < LP_DEPTH);
  assign w_rd_in_range = ({1'b0, i_rd_addr} < LP_DEPTH);

  always_ff @(posedge i_clk) begin
    if (i_wr_en && w_wr_in_range) begin
      r_mem[i_wr_addr[LP_IDX_W-1:0]] <= i_wr_data;
    end
  end

  // Out-of-range reads are masked so the index never leaves the array.
  assign o_rd_data = w_rd_in_range ? r_mem[i_rd_addr[LP_IDX_W-1:0]] : '0;

endmodule

// File: rtl/instr_mem.sv
// Instruction memory with NOP refill sweep, program-load port, registered fetch and halt detect.
//   state    | meaning
//   ST_CLEAR | sweep writes NOP_WORD to word[r_cnt]; fetch/load ignored, busy=1
//   ST_RUN   | loads and fetches accepted, load_ready=1
module instr_mem #(
  parameter int                ADDR_W    = 5,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(instr_mem_pkg::NOP_WORD),
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(instr_mem_pkg::HALT_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              halt_seen,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              busy
);
  import instr_mem_pkg::*;

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_instr, w_instr_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_halt, w_halt_nxt;

  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_load_ok;
  logic              w_fetch_in_range;

  assign w_load_ok        = load_en && ({1'b0, load_addr} < LP_DEPTH);
  assign w_fetch_in_range = ({1'b0, fetch_addr} < LP_DEPTH);

  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .i_clk     (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (fetch_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_instr <= NOP_WORD;
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_halt  <= w_halt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_valid;
    w_halt_nxt  = r_halt || (r_valid && (r_instr == HALT_WORD));
    w_wr_en     = 1'b0;
    w_wr_addr   = load_addr;
    w_wr_data   = load_data;

    case (r_state)
      ST_CLEAR: begin
        w_wr_en     = 1'b1;
        w_wr_addr   = r_cnt;
        w_wr_data   = NOP_WORD;
        w_instr_nxt = NOP_WORD;
        w_valid_nxt = 1'b0;
        if (clear_req) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LP_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        w_wr_en = w_load_ok;
        if (!stall) begin
          if (fetch_req) begin
            w_valid_nxt = 1'b1;
            if (!w_fetch_in_range) begin
              w_instr_nxt = NOP_WORD;
            end else if (w_load_ok && (load_addr == fetch_addr)) begin
              w_instr_nxt = load_data;
            end else begin
              w_instr_nxt = w_rd_data;
            end
          end else begin
            w_instr_nxt = NOP_WORD;
            w_valid_nxt = 1'b0;
          end
        end
        // A refill request overrides stall and any fetch in the same cycle.
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
          w_instr_nxt = NOP_WORD;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase

    if (clear_req) begin
      w_halt_nxt = 1'b0;
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign halt_seen   = r_halt;
  assign busy        = (r_state == ST_CLEAR);
  assign load_ready  = (r_state == ST_RUN);

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed scenarios plus random traffic against a word-level model.
module tb_instr_mem;

  localparam int          AW    = 6;
  localparam int          DW    = 32;
  localparam int          DEP   = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear_req, fetch_req, stall, load_en;
  logic [AW-1:0] fetch_addr, load_addr;
  logic [DW-1:0] load_data;
  logic [DW-1:0] instr;
  logic          instr_valid, halt_seen, load_ready, busy;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: memory contents plus remaining sweep cycles.
  logic [31:0] m_mem [DEP];
  int          m_left;
  logic        m_busy;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_halt;

  instr_mem #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_req   (clear_req),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .halt_seen   (halt_seen),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".instr"},      instr,                m_instr);
    check({tag, ".valid"},      {31'd0, instr_valid}, {31'd0, m_valid});
    check({tag, ".halt"},       {31'd0, halt_seen},   {31'd0, m_halt});
    check({tag, ".busy"},       {31'd0, busy},        {31'd0, m_busy});
    check({tag, ".load_ready"}, {31'd0, load_ready},  {31'd0, !m_busy});
  endtask

  task automatic model_reset();
    m_busy  = 1'b1;
    m_left  = DEP;
    m_instr = NOP;
    m_valid = 1'b0;
    m_halt  = 1'b0;
  endtask

  task automatic model_step();
    logic new_halt;
    new_halt = m_halt || (m_valid && m_instr == HALT);
    if (clear_req) begin
      new_halt = 1'b0;
      m_busy   = 1'b1;
      m_left   = DEP;
      m_instr  = NOP;
      m_valid  = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        for (int i = 0; i < DEP; i++) m_mem[i] = NOP;
      end
      m_instr = NOP;
      m_valid = 1'b0;
    end else begin
      if (!stall) begin
        if (fetch_req) begin
          m_valid = 1'b1;
          if (int'(fetch_addr) >= DEP)
            m_instr = NOP;
          else if (load_en && load_addr == fetch_addr)
            m_instr = load_data;
          else
            m_instr = m_mem[fetch_addr];
        end else begin
          m_instr = NOP;
          m_valid = 1'b0;
        end
      end
      if (load_en && int'(load_addr) < DEP) m_mem[load_addr] = load_data;
    end
    m_halt = new_halt;
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    clear_req  = 1'b0;
    fetch_req  = 1'b0;
    stall      = 1'b0;
    load_en    = 1'b0;
    fetch_addr = '0;
    load_addr  = '0;
    load_data  = '0;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [31:0] d);
    idle();
    load_en = 1'b1; load_addr = a; load_data = d;
    tick("load");
  endtask

  task automatic do_fetch(input logic [AW-1:0] a);
    idle();
    fetch_req = 1'b1; fetch_addr = a;
    tick("fetch");
  endtask

  initial begin
    for (int i = 0; i < DEP; i++) m_mem[i] = NOP;
    idle();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Power-up sweep: busy for exactly DEP cycles.
    for (int i = 0; i < DEP; i++) tick("sweep0");
    check("sweep0_done", {31'd0, load_ready}, 32'd1);

    do_fetch(6'd7);
    check("fetch7", instr, NOP);
    check("fetch7_valid", {31'd0, instr_valid}, 32'd1);

    do_load(6'd0, 32'h0050_0513);
    do_load(6'd3, HALT);
    do_load(6'd2, 32'h1234_5678);
    do_fetch(6'd0);
    check("fetch0", instr, 32'h0050_0513);
    do_fetch(6'd3);
    check("fetch3", instr, HALT);
    idle();
    tick("halt_wait");
    check("halt_set", {31'd0, halt_seen}, 32'd1);

    // Write-first bypass.
    idle();
    load_en = 1'b1; load_addr = 6'd1; load_data = 32'h00C0_00EF;
    fetch_req = 1'b1; fetch_addr = 6'd1;
    tick("bypass");
    check("bypass_instr", instr, 32'h00C0_00EF);

    // Out-of-range fetch and discarded out-of-range load.
    do_load(6'd40, 32'hDEAD_BEEF);
    do_fetch(6'd40);
    check("oor_fetch", instr, NOP);
    check("oor_valid", {31'd0, instr_valid}, 32'd1);

    // Stall hold, with a load completing under stall.
    do_fetch(6'd0);
    idle();
    fetch_req = 1'b1; fetch_addr = 6'd2; stall = 1'b1;
    load_en = 1'b1; load_addr = 6'd5; load_data = 32'hA5A5_0001;
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall_hold", instr, 32'h0050_0513);
    end
    stall = 1'b0; load_en = 1'b0;
    tick("unstall");
    check("unstall_instr", instr, 32'h1234_5678);
    do_fetch(6'd5);
    check("load_under_stall", instr, 32'hA5A5_0001);

    // Refill with halt_seen set.
    check("pre_clear_halt", {31'd0, halt_seen}, 32'd1);
    idle();
    clear_req = 1'b1;
    tick("clear");
    check("clear_valid", {31'd0, instr_valid}, 32'd0);
    check("clear_halt", {31'd0, halt_seen}, 32'd0);
    idle();
    for (int i = 0; i < DEP; i++) tick("sweep1");
    for (int i = 0; i < DEP; i++) begin
      do_fetch(AW'(i));
      check("refilled", instr, NOP);
    end

    // Random traffic, including refill requests in either state.
    for (int i = 0; i < 600; i++) begin
      clear_req  = ($urandom_range(0, 79) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      fetch_req  = ($urandom_range(0, 2) != 0);
      load_en    = $urandom_range(0, 1) == 1;
      load_addr  = AW'($urandom_range(0, 39));
      fetch_addr = ($urandom_range(0, 3) == 0) ? load_addr : AW'($urandom_range(0, 39));
      load_data  = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      tick("rand");
    end

    // Reset in the middle of a sweep.
    idle();
    clear_req = 1'b1;
    tick("clear2");
    idle();
    for (int i = 0; i < 10; i++) tick("sweep2");
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all("midreset");
    @(posedge clk); #1;
    check_all("midreset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      tick("sweep3");
      check("sweep3_busy", {31'd0, busy}, (i < DEP - 1) ? 32'd1 : 32'd0);
    end
    do_fetch(6'd9);
    check("post_reset_fetch", instr, NOP);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
